// File: rtl/br_fifo_shared_push_arbiter.sv
// Round-robin push arbiter sharing one downstream FIFO among several ready/valid
// requesters, with a per-requester cap on entries resident in that FIFO.
module br_fifo_shared_push_arbiter #(
    parameter int NumRequesters   = 2,
    parameter int Width           = 8,
    parameter int MaxPerRequester = 2,
    localparam int IdWidth        = $clog2(NumRequesters),
    localparam int CountWidth     = $clog2(MaxPerRequester + 1)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NumRequesters-1:0]            in_valid,
    output logic [NumRequesters-1:0]            in_ready,
    input  logic [NumRequesters*Width-1:0]      in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [Width-1:0]                    out_data,
    output logic [IdWidth-1:0]                  out_id,
    input  logic                                release_valid,
    input  logic [IdWidth-1:0]                  release_id,
    output logic [NumRequesters*CountWidth-1:0] occupancy
);

    logic [IdWidth-1:0]    rr_ptr;
    logic                  lock_active;
    logic [IdWidth-1:0]    lock_id;
    logic [CountWidth-1:0] occ_cnt [NumRequesters];

    logic [NumRequesters-1:0] eligible;
    logic                     scan_found;
    logic [IdWidth-1:0]       scan_id;
    logic [IdWidth-1:0]       grant_id;

    function automatic logic [IdWidth-1:0] next_ptr(input logic [IdWidth-1:0] id);
        if (int'(id) == NumRequesters - 1) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    // Increment on accept, decrement on release; a stray release at zero holds at zero.
    function automatic logic [CountWidth-1:0] occ_next(input logic [CountWidth-1:0] cur,
                                                       input logic inc,
                                                       input logic dec);
        if (inc && !dec) begin
            return cur + 1'b1;
        end
        if (dec && !inc && cur != '0) begin
            return cur - 1'b1;
        end
        return cur;
    endfunction

    // Only the registered count gates eligibility, so release never reaches the grant combinationally.
    always_comb begin
        for (int i = 0; i < NumRequesters; i++) begin
            eligible[i] = in_valid[i] && (occ_cnt[i] < CountWidth'(MaxPerRequester));
        end
    end

    always_comb begin
        scan_found = 1'b0;
        scan_id    = '0;
        for (int k = 0; k < NumRequesters; k++) begin
            automatic int idx = int'(rr_ptr) + k;
            if (idx >= NumRequesters) begin
                idx = idx - NumRequesters;
            end
            if (!scan_found && eligible[idx]) begin
                scan_found = 1'b1;
                scan_id    = IdWidth'(idx);
            end
        end
    end

    // A lock pins the grant while the FIFO stalls so the presented entry cannot change.
    always_comb begin
        grant_id  = lock_active ? lock_id : scan_id;
        out_valid = rst_n && (lock_active || scan_found);
        out_id    = grant_id;
        out_data  = in_data[int'(grant_id)*Width +: Width];
        for (int i = 0; i < NumRequesters; i++) begin
            in_ready[i] = out_valid && out_ready && (grant_id == IdWidth'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NumRequesters; i++) begin
            occupancy[i*CountWidth +: CountWidth] = occ_cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            lock_active <= 1'b0;
            lock_id     <= '0;
            for (int i = 0; i < NumRequesters; i++) begin
                occ_cnt[i] <= '0;
            end
        end else begin
            if (out_valid && out_ready) begin
                rr_ptr      <= next_ptr(grant_id);
                lock_active <= 1'b0;
            end else if (out_valid) begin
                lock_active <= 1'b1;
                lock_id     <= grant_id;
            end
            for (int i = 0; i < NumRequesters; i++) begin
                occ_cnt[i] <= occ_next(occ_cnt[i], in_ready[i],
                                       release_valid && (release_id == IdWidth'(i)));
            end
        end
    end

`ifndef SYNTHESIS
    // Cycles each eligible requester has watched the FIFO accept someone else.
    int wait_cnt [NumRequesters];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NumRequesters; i++) begin
            if (!rst_n || !eligible[i] || in_ready[i]) begin
                wait_cnt[i] <= 0;
            end else if (out_ready) begin
                wait_cnt[i] <= wait_cnt[i] + 1;
            end
        end
    end

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_ready));

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(out_id) && $stable(out_data));

    a_release_id_range: assert property (@(posedge clk) disable iff (!rst_n)
        release_valid |-> ({1'b0, release_id} < (IdWidth+1)'(NumRequesters)));

    for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_chk
        a_occ_max: assert property (@(posedge clk) disable iff (!rst_n)
            occ_cnt[gi] <= CountWidth'(MaxPerRequester));

        a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
            release_valid && (release_id == IdWidth'(gi)) |-> occ_cnt[gi] != '0);

        a_liveness: assert property (@(posedge clk) disable iff (!rst_n)
            wait_cnt[gi] <= NumRequesters);
    end
`endif

endmodule

// File: doc/br_fifo_shared_push_arbiter.md
Name: br_fifo_shared_push_arbiter

Overview:
- Shares the push interface of a single downstream FIFO among NumRequesters ready/valid push channels.
- Arbitration is round-robin. Each requester has an occupancy quota: at most MaxPerRequester of its entries may be resident in the FIFO at once.
- The pop side of the FIFO returns the requester ID of each popped entry via the release port, freeing that requester's quota.
- Sits directly in front of a br_fifo push port; out_id is stored alongside the data (or in a sideband FIFO).

Parameters:
- NumRequesters, 2, number of push channels; must be at least 2.
- Width, 8, payload width per entry; must be at least 1.
- MaxPerRequester, 2, maximum resident entries per requester; must be at least 1.
- IdWidth (localparam), $clog2(NumRequesters), requester ID width.
- CountWidth (localparam), $clog2(MaxPerRequester+1), per-requester occupancy counter width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  NumRequesters  per-requester push valid.
- in_ready  output  NumRequesters  per-requester push ready.
- in_data  input  NumRequesters*Width  per-requester payload; requester i occupies bits [i*Width +: Width].
- out_valid  output  1  push valid to the FIFO.
- out_ready  input  1  push ready from the FIFO.
- out_data  output  Width  payload of the granted requester.
- out_id  output  IdWidth  ID of the granted requester.
- release_valid  input  1  one entry popped from the FIFO.
- release_id  input  IdWidth  owner of the popped entry.
- occupancy  output  NumRequesters*CountWidth  per-requester resident count, registered.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all occupancy counters = 0, RR pointer = 0, lock = 0.
  - Outputs during reset: out_valid=0, in_ready=0. out_data and out_id are don't-care.
- Eligibility: eligible[i] = in_valid[i] && occupancy[i] < MaxPerRequester.
  - Uses the registered count only. A release in the current cycle frees quota from the next cycle, so there is no combinational path from release_* to grant.
- Grant, unlocked:
  - Select the first eligible requester scanning upward from the RR pointer, with wrap.
  - out_valid = any eligible; out_data/out_id come from the granted requester.
- Grant, locked:
  - Force the grant to the locked ID. out_valid = 1.
  - Requesters must hold in_valid and in_data stable while not ready (upstream protocol requirement).
  - Quota cannot drop below the level that made the locked requester eligible, so it stays eligible.
- Handshake:
  - in_ready[i] = grant[i] && out_ready. At most one bit of in_ready is set per cycle.
  - Zero-cycle latency, combinational in->out.
  - out_valid must not depend on out_ready.
- Lock register:
  - Set with lock_id = granted ID when out_valid && !out_ready.
  - Cleared on the cycle out_valid && out_ready.
  - Guarantees out_valid/out_data/out_id are stable under backpressure.
- RR pointer: on accept of requester i, the pointer becomes (i+1) mod NumRequesters; otherwise it is unchanged.
- Occupancy: occupancy[i] next = occupancy[i] + accept[i] - (release_valid && release_id==i).
  - Simultaneous accept and release for the same i leaves the count unchanged.
  - Release with occupancy[i]==0 is illegal: assertion fires and the count holds at 0, no underflow.
  - release_id >= NumRequesters is illegal: assertion fires.
  - occupancy[i] never exceeds MaxPerRequester (asserted).
- Reset mid-operation: all state clears regardless of lock or pending transfers. No entries are assumed resident in the FIFO after reset, so the FIFO must be reset together with this block.
- Non-power-of-two NumRequesters: the pointer wraps at NumRequesters-1 to 0. IDs >= NumRequesters are never produced.
- Required assertions:
  - onehot0(in_ready).
  - out_valid && !out_ready |=> out_valid && $stable(out_id) && $stable(out_data).
  - Liveness: in_valid[i] held, with quota eventually free, implies eventually in_ready[i].

Test Plan:
- Reset, then N=2 with both in_valid high, out_ready=1, no releases, Max=2 -> accepts alternate 0,1,0,1. After 4 cycles occupancy = {2,2} and out_valid=0.
- From that state, release_valid=1 with release_id=1 for one cycle -> next cycle occupancy[1]=1 and requester 1 is granted. Requester 0 stays blocked.
- Requester 0 granted with out_ready=0 for 3 cycles while requester 1 also valid -> out_id=0 and out_data stay stable for all 3 cycles. When out_ready rises, requester 0 is accepted and the next grant goes to 1.
- Accept and release for requester 1 in the same cycle at occupancy[1]=1 -> occupancy[1] stays 1.
- N=3, only requester 2 valid, pointer=0 -> grant 2 (wrap scan). After accept the pointer is 0, and requester 0 becomes the top priority.
- Assert rst_n=0 while locked with occupancy {1,2} -> next cycle out_valid=0, in_ready=0, occupancy {0,0}, lock cleared. After release from reset, grant starts from requester 0.
